gear_shift_ctrl: RTL and testbench

GEAR_SHIFT_CTRL -- requirements
Module: gear_shift_ctrl

---
 rtl/gear_pkg.sv | 28 ++
 rtl/gear_dwell_timer.sv | 36 +++
 rtl/gear_shift_ctrl.sv | 167 ++++++++++++++++
 tb/tb_gear_shift_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/gear_pkg.sv
// Shared types, default parameters and sizing helper for the gear shift controller.
package gear_pkg;

  localparam int unsigned DefNumGears    = 5;
  localparam int unsigned DefShiftCycles = 4;
  localparam int unsigned DefDwellCycles = 16;
  localparam int unsigned GearW          = 3;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDwell,
    StHalt
  } gear_state_e;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } gear_dir_e;

  // Counter must hold the longest phase length itself, hence the extra bit.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/gear_dwell_timer.sv
// Down-counting phase timer: reloaded on every state entry, flags the last cycle of a phase.
module gear_dwell_timer #(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] count_o,
  output logic             done_o
);

  logic [Width-1:0] count_q, count_d;

  // Saturates at zero so an idle timer never wraps.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = (count_q == Width'(1));

endmodule

// File: rtl/gear_shift_ctrl.sv
// Sequential gearbox controller: timed shift and dwell phases, one-deep request queue, e-stop.
module gear_shift_ctrl
  import gear_pkg::*;
#(
  parameter int unsigned NUM_GEARS    = DefNumGears,
  parameter int unsigned SHIFT_CYCLES = DefShiftCycles,
  parameter int unsigned DWELL_CYCLES = DefDwellCycles
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_up,
  input  logic             req_down,
  input  logic             estop,
  output logic [GearW-1:0] gear,
  output logic             shifting,
  output logic             busy,
  output logic             rej
);

  localparam int unsigned      TimerW    = timer_width(SHIFT_CYCLES, DWELL_CYCLES);
  localparam logic [TimerW-1:0] ShiftLoad = TimerW'(SHIFT_CYCLES);
  localparam logic [TimerW-1:0] DwellLoad = TimerW'(DWELL_CYCLES);
  localparam logic [GearW-1:0]  TopGear   = GearW'(NUM_GEARS - 1);

  gear_state_e      state_q, state_d;
  gear_dir_e        dir_q, dir_d;
  gear_dir_e        pend_dir_q, pend_dir_d;
  logic             pend_vld_q, pend_vld_d;
  logic [GearW-1:0] gear_q, gear_d;
  logic             shifting_q, busy_q, rej_q, rej_d;

  logic              tmr_load;
  logic [TimerW-1:0] tmr_val;
  logic [TimerW-1:0] tmr_count;
  logic              tmr_done;
  logic              tmr_expired;

  logic      req_any;
  gear_dir_e req_dir;
  logic      cand_vld;
  gear_dir_e cand_dir;
  logic      cand_ok;

  gear_dwell_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (resetn),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .count_o   (tmr_count),
    .done_o    (tmr_done)
  );

  // An already-exhausted counter also ends the phase, so a zero-length phase cannot stall.
  assign tmr_expired = tmr_done | (tmr_count == '0);

  // Down wins a simultaneous request; the dropped up is silently discarded.
  assign req_any = req_up | req_down;
  assign req_dir = req_down ? DirDown : DirUp;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;
    gear_d     = gear_q;
    rej_d      = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    cand_vld   = 1'b0;
    cand_dir   = DirUp;
    cand_ok    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A queued request takes this cycle's slot; a concurrent new one finds the slot full.
        cand_vld   = pend_vld_q | req_any;
        cand_dir   = pend_vld_q ? pend_dir_q : req_dir;
        cand_ok    = (cand_dir == DirUp) ? (gear_q < TopGear) : (gear_q != '0);
        pend_vld_d = 1'b0;
        if (pend_vld_q && req_any) begin
          rej_d = 1'b1;
        end
        if (cand_vld) begin
          if (cand_ok) begin
            state_d  = StShift;
            dir_d    = cand_dir;
            tmr_load = 1'b1;
            tmr_val  = ShiftLoad;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      StShift, StDwell: begin
        if (req_any) begin
          if (!pend_vld_q) begin
            pend_vld_d = 1'b1;
            pend_dir_d = req_dir;
          end else begin
            rej_d = 1'b1;
          end
        end
        if (tmr_expired) begin
          if (state_q == StShift) begin
            state_d  = StDwell;
            tmr_load = 1'b1;
            tmr_val  = DwellLoad;
            if (dir_q == DirUp && gear_q < TopGear) begin
              gear_d = gear_q + 1'b1;
            end else if (dir_q == DirDown && gear_q != '0) begin
              gear_d = gear_q - 1'b1;
            end
          end else begin
            state_d = StIdle;
          end
        end
      end
      StHalt: begin
        if (!estop) begin
          state_d  = StDwell;
          tmr_load = 1'b1;
          tmr_val  = DwellLoad;
        end
      end
      default: state_d = StIdle;
    endcase

    if (estop) begin
      state_d    = StHalt;
      gear_d     = '0;
      pend_vld_d = 1'b0;
      rej_d      = 1'b0;
      tmr_load   = 1'b1;
      tmr_val    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q    <= StIdle;
      dir_q      <= DirUp;
      pend_vld_q <= 1'b0;
      pend_dir_q <= DirUp;
      gear_q     <= '0;
      shifting_q <= 1'b0;
      busy_q     <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
      gear_q     <= gear_d;
      shifting_q <= (state_d == StShift);
      busy_q     <= (state_d != StIdle);
      rej_q      <= rej_d;
    end
  end

  assign gear     = gear_q;
  assign shifting = shifting_q;
  assign busy     = busy_q;
  assign rej      = rej_q;

endmodule

// File: tb/tb_gear_shift_ctrl.sv
// Directed bench for gear_shift_ctrl with hand-computed cycle expectations.
module tb_gear_shift_ctrl;

  logic       clk;
  logic       resetn;
  logic       req_up;
  logic       req_down;
  logic       estop;
  logic [2:0] gear;
  logic       shifting;
  logic       busy;
  logic       rej;

  int n_checks;
  int n_fail;

  gear_shift_ctrl dut (
    .clk     (clk),
    .resetn  (resetn),
    .req_up  (req_up),
    .req_down(req_down),
    .estop   (estop),
    .gear    (gear),
    .shifting(shifting),
    .busy    (busy),
    .rej     (rej)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
  endtask

  task automatic pulse(input logic up, input logic down);
    req_up   = up;
    req_down = down;
    tick();
    req_up   = 1'b0;
    req_down = 1'b0;
  endtask

  // Full shift from IDLE back to IDLE: 1 request cycle + 4 shift + 16 dwell.
  task automatic full_shift(input logic up);
    pulse(up, ~up);
    repeat (20) tick();
  endtask

  logic rej_seen;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    req_up   = 1'b0;
    req_down = 1'b0;
    estop    = 1'b0;
    rej_seen = 1'b0;
    tick();

    // Reset state and basic up-shift timing.
    do_reset();
    check_eq("rst_gear", gear, 0);
    check_eq("rst_shifting", shifting, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rej", rej, 0);
    pulse(1'b1, 1'b0);
    check_eq("up_shifting_t1", shifting, 1);
    check_eq("up_busy_t1", busy, 1);
    check_eq("up_gear_t1", gear, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("up_shifting_hold", shifting, 1);
    end
    tick();
    check_eq("up_shifting_t5", shifting, 0);
    check_eq("up_gear_t5", gear, 1);
    repeat (15) tick();
    check_eq("up_busy_t20", busy, 1);
    tick();
    check_eq("up_busy_t21", busy, 0);

    // Refused requests at the top and bottom gears.
    do_reset();
    repeat (4) full_shift(1'b1);
    check_eq("top_gear", gear, 4);
    pulse(1'b1, 1'b0);
    check_eq("top_rej", rej, 1);
    check_eq("top_gear_hold", gear, 4);
    check_eq("top_busy", busy, 0);
    tick();
    check_eq("top_rej_clear", rej, 0);
    do_reset();
    pulse(1'b0, 1'b1);
    check_eq("bot_rej", rej, 1);
    check_eq("bot_gear_hold", gear, 0);
    check_eq("bot_busy", busy, 0);

    // Simultaneous up and down: down wins, no refusal.
    do_reset();
    repeat (2) full_shift(1'b1);
    check_eq("both_gear_start", gear, 2);
    pulse(1'b1, 1'b1);
    rej_seen = rej;
    check_eq("both_shifting", shifting, 1);
    repeat (20) begin
      tick();
      rej_seen = rej_seen | rej;
    end
    check_eq("both_no_rej", rej_seen, 0);
    check_eq("both_gear_end", gear, 1);

    // Pending slot: first request queued, second refused, queued one executes after dwell.
    do_reset();
    full_shift(1'b1);
    pulse(1'b1, 1'b0);
    repeat (4) tick();
    check_eq("pend_gear_2", gear, 2);
    tick();
    pulse(1'b1, 1'b0);
    check_eq("pend_first_no_rej", rej, 0);
    pulse(1'b0, 1'b1);
    check_eq("pend_second_rej", rej, 1);
    repeat (13) tick();
    check_eq("pend_idle_busy", busy, 0);
    check_eq("pend_gear_still_2", gear, 2);
    tick();
    check_eq("pend_shift_start", shifting, 1);
    repeat (4) tick();
    check_eq("pend_gear_3", gear, 3);

    // Emergency stop mid-shift with a queued request.
    do_reset();
    repeat (3) full_shift(1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    estop = 1'b1;
    tick();
    check_eq("estop_gear", gear, 0);
    check_eq("estop_busy", busy, 1);
    check_eq("estop_shifting", shifting, 0);
    check_eq("estop_rej", rej, 0);
    pulse(1'b1, 1'b0);
    check_eq("halt_req_no_rej", rej, 0);
    check_eq("halt_gear", gear, 0);
    estop = 1'b0;
    tick();
    check_eq("halt_exit_busy", busy, 1);
    repeat (15) tick();
    check_eq("halt_dwell_end_busy", busy, 1);
    tick();
    check_eq("halt_idle_busy", busy, 0);
    tick();
    check_eq("halt_pend_empty", shifting, 0);
    check_eq("halt_pend_empty_busy", busy, 0);

    // Reset mid-dwell overrides estop and the in-progress change.
    do_reset();
    repeat (2) full_shift(1'b1);
    pulse(1'b1, 1'b0);
    repeat (5) tick();
    check_eq("mid_dwell_gear", gear, 3);
    resetn = 1'b1;
    estop  = 1'b1;
    tick();
    check_eq("rst_mid_gear", gear, 0);
    check_eq("rst_mid_shifting", shifting, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_rej", rej, 0);
    resetn = 1'b0;
    estop  = 1'b0;
    tick();
    check_eq("rst_mid_after_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
